// File: rtl/axi4_a_split_pkg.sv
// Shared A-channel constants: atype encoding used by the combined-channel mux and splitter.
package axi4_a_split_pkg;
  localparam logic ATYPE_WRITE = 1'b1;
  localparam logic ATYPE_READ  = 1'b0;
endpackage

// File: rtl/axi4_a_split_fifo.sv
// Level-counted FIFO, registered head (>=1 cycle push-to-output); refuses pushes when full,
// even in a cycle that also pops.
module axi4_a_split_fifo #(
  parameter int WIDTH = 48,
  parameter int DEPTH = 2
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       push_dat_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       head_dat_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] level_o
);
  localparam int PW = $clog2(DEPTH);
  localparam int LW = PW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]    level_q, level_d;
  logic             push_en, pop_en;

  assign full_o     = (level_q == LW'(DEPTH));
  assign empty_o    = (level_q == '0);
  assign level_o    = level_q;
  assign head_dat_o = mem_q[rd_ptr_q];
  assign push_en    = push_i && !full_o;
  assign pop_en     = pop_i && !empty_o;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_en) begin
      mem_d[wr_ptr_q] = push_dat_i;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    if (pop_en) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    // Simultaneous push and pop leaves the level unchanged.
    case ({push_en, pop_en})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
  end

  // Payload storage carries no reset; the pointers alone define validity.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end
endmodule

// File: rtl/axi4_a_split.sv
// Splits a combined A channel into AW/AR through independent FIFOs: 1-cycle minimum latency;
// aready_o reflects only the FIFO selected by atype_i, so a stalled direction never blocks the other.
module axi4_a_split
  import axi4_a_split_pkg::*;
#(
  parameter int AID_LEN    = 8,
  parameter int AADDR_LEN  = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                        aclk_i,
  input  logic                        arstn_i,
  input  logic [AID_LEN-1:0]          aid_i,
  input  logic [AADDR_LEN-1:0]        aaddr_i,
  input  logic [7:0]                  alen_i,
  input  logic                        atype_i,
  input  logic                        avalid_i,
  output logic                        aready_o,
  output logic [AID_LEN-1:0]          awid_o,
  output logic [AADDR_LEN-1:0]        awaddr_o,
  output logic [7:0]                  awlen_o,
  output logic                        awvalid_o,
  input  logic                        awready_i,
  output logic [AID_LEN-1:0]          arid_o,
  output logic [AADDR_LEN-1:0]        araddr_o,
  output logic [7:0]                  arlen_o,
  output logic                        arvalid_o,
  input  logic                        arready_i,
  output logic [$clog2(FIFO_DEPTH):0] aw_level_o,
  output logic [$clog2(FIFO_DEPTH):0] ar_level_o
);
  localparam int W = AID_LEN + AADDR_LEN + 8;

  logic [W-1:0] a_dat, aw_dat, ar_dat;
  logic         aw_full, ar_full, aw_empty, ar_empty;
  logic         aw_push, ar_push;

  assign a_dat    = {aid_i, aaddr_i, alen_i};
  assign aready_o = (atype_i == ATYPE_WRITE) ? !aw_full : !ar_full;
  assign aw_push  = avalid_i && aready_o && (atype_i == ATYPE_WRITE);
  assign ar_push  = avalid_i && aready_o && (atype_i == ATYPE_READ);

  assign awvalid_o                     = !aw_empty;
  assign arvalid_o                     = !ar_empty;
  assign {awid_o, awaddr_o, awlen_o}   = aw_dat;
  assign {arid_o, araddr_o, arlen_o}   = ar_dat;

  axi4_a_split_fifo #(.WIDTH(W), .DEPTH(FIFO_DEPTH)) u_aw_fifo (
    .clk_i      (aclk_i),
    .rst_ni     (arstn_i),
    .push_i     (aw_push),
    .push_dat_i (a_dat),
    .pop_i      (awvalid_o && awready_i),
    .head_dat_o (aw_dat),
    .full_o     (aw_full),
    .empty_o    (aw_empty),
    .level_o    (aw_level_o)
  );

  axi4_a_split_fifo #(.WIDTH(W), .DEPTH(FIFO_DEPTH)) u_ar_fifo (
    .clk_i      (aclk_i),
    .rst_ni     (arstn_i),
    .push_i     (ar_push),
    .push_dat_i (a_dat),
    .pop_i      (arvalid_o && arready_i),
    .head_dat_o (ar_dat),
    .full_o     (ar_full),
    .empty_o    (ar_empty),
    .level_o    (ar_level_o)
  );
endmodule

// File: tb/tb_axi4_a_split.sv
// Directed bench for axi4_a_split; a negedge monitor scoreboards AW/AR payload order.
module tb_axi4_a_split;
  localparam int IDW = 8;
  localparam int AW  = 32;
  localparam int D   = 2;
  localparam int LW  = $clog2(D) + 1;
  localparam int PW  = IDW + AW + 8;

  logic           aclk_i = 1'b0;
  logic           arstn_i;
  logic [IDW-1:0] aid_i;
  logic [AW-1:0]  aaddr_i;
  logic [7:0]     alen_i;
  logic           atype_i, avalid_i, aready_o;
  logic [IDW-1:0] awid_o, arid_o;
  logic [AW-1:0]  awaddr_o, araddr_o;
  logic [7:0]     awlen_o, arlen_o;
  logic           awvalid_o, awready_i, arvalid_o, arready_i;
  logic [LW-1:0]  aw_level_o, ar_level_o;

  axi4_a_split #(.AID_LEN(IDW), .AADDR_LEN(AW), .FIFO_DEPTH(D)) dut (
    .aclk_i(aclk_i), .arstn_i(arstn_i),
    .aid_i(aid_i), .aaddr_i(aaddr_i), .alen_i(alen_i), .atype_i(atype_i),
    .avalid_i(avalid_i), .aready_o(aready_o),
    .awid_o(awid_o), .awaddr_o(awaddr_o), .awlen_o(awlen_o),
    .awvalid_o(awvalid_o), .awready_i(awready_i),
    .arid_o(arid_o), .araddr_o(araddr_o), .arlen_o(arlen_o),
    .arvalid_o(arvalid_o), .arready_i(arready_i),
    .aw_level_o(aw_level_o), .ar_level_o(ar_level_o)
  );

  always #5 aclk_i = ~aclk_i;

  int total = 0;
  int bad = 0;
  int aw_pops = 0;
  logic [PW-1:0] exp_aw[$];
  logic [PW-1:0] exp_ar[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // Pop checks run before the push so a pass-through cannot hide behind its own expectation.
  always @(negedge aclk_i) begin
    if (!arstn_i) begin
      exp_aw.delete();
      exp_ar.delete();
    end else begin
      if (awvalid_o && awready_i) begin
        aw_pops++;
        if (exp_aw.size() == 0) begin
          total++; bad++;
          $display("FAIL aw_unexpected: got 0x%0h want none", {awid_o, awaddr_o, awlen_o});
        end else chk("aw_payload", {16'h0, awid_o, awaddr_o, awlen_o}, {16'h0, exp_aw.pop_front()});
      end
      if (arvalid_o && arready_i) begin
        if (exp_ar.size() == 0) begin
          total++; bad++;
          $display("FAIL ar_unexpected: got 0x%0h want none", {arid_o, araddr_o, arlen_o});
        end else chk("ar_payload", {16'h0, arid_o, araddr_o, arlen_o}, {16'h0, exp_ar.pop_front()});
      end
      if (avalid_i && aready_o) begin
        if (atype_i) exp_aw.push_back({aid_i, aaddr_i, alen_i});
        else         exp_ar.push_back({aid_i, aaddr_i, alen_i});
      end
    end
  end

  task automatic step();
    @(posedge aclk_i);
    #1;
  endtask

  // Entered and left at posedge+1; reports how many cycles aready_o was low.
  task automatic send(input logic t, input logic [IDW-1:0] id, input logic [AW-1:0] addr,
                      input logic [7:0] len, output int waited);
    avalid_i = 1'b1; atype_i = t; aid_i = id; aaddr_i = addr; alen_i = len; waited = 0;
    @(negedge aclk_i);
    while (!aready_o && waited < 20) begin
      waited++;
      @(negedge aclk_i);
    end
    if (!aready_o) begin
      total++; bad++;
      $display("FAIL send_timeout: aready_o got 0 want 1");
    end
    @(posedge aclk_i);
    #1;
    avalid_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, p0;
    arstn_i = 1'b0; avalid_i = 1'b0; atype_i = 1'b0; aid_i = '0; aaddr_i = '0; alen_i = '0;
    awready_i = 1'b0; arready_i = 1'b0;
    #3;
    chk("rst_awvalid", awvalid_o, 0);
    chk("rst_arvalid", arvalid_o, 0);
    chk("rst_aw_level", aw_level_o, 0);
    chk("rst_ar_level", ar_level_o, 0);
    chk("rst_aready_rd", aready_o, 1);
    atype_i = 1'b1; #1;
    chk("rst_aready_wr", aready_o, 1);
    @(negedge aclk_i);
    arstn_i = 1'b1;
    step();

    // Single write: visible next cycle, AR untouched
    avalid_i = 1'b1; atype_i = 1'b1; aid_i = 8'd3; aaddr_i = 32'h100; alen_i = 8'd7;
    @(negedge aclk_i);
    chk("t1_no_passthru", awvalid_o, 0);
    step(); avalid_i = 1'b0;
    @(negedge aclk_i);
    chk("t1_awvalid", awvalid_o, 1);
    chk("t1_aw_level", aw_level_o, 1);
    chk("t1_arvalid", arvalid_o, 0);
    chk("t1_awid", awid_o, 3);
    chk("t1_awaddr", awaddr_o, 32'h100);
    chk("t1_awlen", awlen_o, 7);
    step(); awready_i = 1'b1;
    step(); awready_i = 1'b0;
    @(negedge aclk_i);
    chk("t1_aw_drained", aw_level_o, 0);
    step();

    // Fill AR with arready low
    send(1'b0, 8'd1, 32'hA0, 8'd0, w); chk("t2_wait0", w, 0);
    send(1'b0, 8'd1, 32'hA1, 8'd0, w); chk("t2_wait1", w, 0);
    @(negedge aclk_i);
    chk("t2_ar_level", ar_level_o, 2);
    chk("t2_aready_rd_full", aready_o, 0);
    step();

    // Write while AR is full and stalled
    send(1'b1, 8'd5, 32'h200, 8'd1, w); chk("t3_wr_wait", w, 0);
    @(negedge aclk_i);
    chk("t3_awvalid", awvalid_o, 1);
    chk("t3_ar_level", ar_level_o, 2);
    chk("t3_ar_head", araddr_o, 32'hA0);
    step(); awready_i = 1'b1;
    step(); awready_i = 1'b0;

    // Third read waits for a pop; no same-cycle full bypass
    avalid_i = 1'b1; atype_i = 1'b0; aid_i = 8'd1; aaddr_i = 32'hA2; alen_i = 8'd0;
    @(negedge aclk_i);
    chk("t2_rd3_blocked", aready_o, 0);
    step(); arready_i = 1'b1;
    @(negedge aclk_i);
    chk("t2_no_bypass", aready_o, 0);
    step(); arready_i = 1'b0;
    @(negedge aclk_i);
    chk("t2_after_pop_ready", aready_o, 1);
    chk("t2_after_pop_level", ar_level_o, 1);
    step(); avalid_i = 1'b0;
    @(negedge aclk_i);
    chk("t2_rd3_level", ar_level_o, 2);
    step(); arready_i = 1'b1;
    for (int i = 0; i < 20 && ar_level_o != 0; i++) step();
    chk("t2_ar_drained", ar_level_o, 0);
    arready_i = 1'b0;

    // Simultaneous push and pop at level 1
    send(1'b1, 8'd2, 32'h10, 8'd0, w);
    avalid_i = 1'b1; atype_i = 1'b1; aid_i = 8'd2; aaddr_i = 32'h20; alen_i = 8'd0;
    awready_i = 1'b1;
    @(negedge aclk_i);
    chk("t4_aready", aready_o, 1);
    chk("t4_level_before", aw_level_o, 1);
    step(); avalid_i = 1'b0; awready_i = 1'b0;
    @(negedge aclk_i);
    chk("t4_level_after", aw_level_o, 1);
    chk("t4_head", awaddr_o, 32'h20);
    step(); awready_i = 1'b1;
    step(); awready_i = 1'b0;
    @(negedge aclk_i);
    chk("t4_drained", aw_level_o, 0);
    step();

    // Five streaming writes wrap the pointers
    p0 = aw_pops;
    awready_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      send(1'b1, 8'(i), 32'(i * 16), 8'd0, w);
      chk("t5_wait", w, 0);
    end
    step(); step(); step();
    @(negedge aclk_i);
    chk("t5_level", aw_level_o, 0);
    chk("t5_pops", aw_pops - p0, 5);
    step(); awready_i = 1'b0;

    // Reset with both FIFOs full
    send(1'b1, 8'd7, 32'hB0, 8'd0, w);
    send(1'b1, 8'd7, 32'hB1, 8'd0, w);
    send(1'b0, 8'd8, 32'hC0, 8'd0, w);
    send(1'b0, 8'd8, 32'hC1, 8'd0, w);
    @(negedge aclk_i);
    chk("t6_aw_full", aw_level_o, 2);
    chk("t6_ar_full", ar_level_o, 2);
    @(posedge aclk_i);
    #2; arstn_i = 1'b0;
    #1;
    chk("t6_awvalid", awvalid_o, 0);
    chk("t6_arvalid", arvalid_o, 0);
    chk("t6_aw_level", aw_level_o, 0);
    chk("t6_ar_level", ar_level_o, 0);
    chk("t6_aready_rd", aready_o, 1);
    atype_i = 1'b1; #1;
    chk("t6_aready_wr", aready_o, 1);
    @(negedge aclk_i);
    @(posedge aclk_i);
    #1; arstn_i = 1'b1;
    avalid_i = 1'b1; atype_i = 1'b1; aid_i = 8'd9; aaddr_i = 32'h300; alen_i = 8'd2;
    step(); avalid_i = 1'b0;
    @(negedge aclk_i);
    chk("t6_first_push", aw_level_o, 1);
    chk("t6_head", awaddr_o, 32'h300);
    chk("t6_no_stale_ar", arvalid_o, 0);
    step(); awready_i = 1'b1; arready_i = 1'b1;
    step(); step(); step();
    @(negedge aclk_i);
    chk("end_aw_level", aw_level_o, 0);
    chk("end_ar_level", ar_level_o, 0);
    chk("end_exp_aw_left", exp_aw.size(), 0);
    chk("end_exp_ar_left", exp_ar.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
